// File: rtl/i4002_ram.sv
// ---------------------------------------------------------------------------
// i4002_ram -- MCS-4 style 4002 data RAM with 4-bit output port.
//
// Tracks the 8-phase MCS-4 instruction cycle by watching PHI2 rising edges
// (sampled on clk_i), decodes SRC addressing and the RAM I/O instructions
// that the CPU announces with CM-RAM, and drives the data bus during X2 of
// read instructions.
//
// Storage: 4 registers x (16 main + 4 status) characters of 4 bits.
// The array has no reset; only control state is cleared.
//
// Ports:
//   clk_i    in   1  system clock, all state changes on rising edge
//   rst_ni   in   1  asynchronous active-low reset
//   PHI1_i   in   1  clock phase 1, qualifier only
//   PHI2_i   in   1  clock phase 2, its rising edge advances the phase
//   SYNC_i   in   1  CPU SYNC, next phase is A1 when high at an advance
//   CM_i     in   1  CM-RAM line
//   D_i      in   4  data bus from the CPU
//   D_o      out  4  data bus value driven by this chip
//   D_oe_o   out  1  bus drive enable
//   PORT_o   out  4  latched output port
//
// Parameter CHIP_ID selects which SRC D3:D2 value addresses this chip.
// Optional feature macro: I4002_OUTPUT_PORT_EN (defined -> WMP drives
// PORT_o through a register; undefined -> PORT_o is constant 4'h0).
// ---------------------------------------------------------------------------
module i4002_ram #(
    parameter logic [1:0] CHIP_ID = 2'd0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       PHI1_i,
    input  logic       PHI2_i,
    input  logic       SYNC_i,
    input  logic       CM_i,
    input  logic [3:0] D_i,
    output logic [3:0] D_o,
    output logic       D_oe_o,
    output logic [3:0] PORT_o
);

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_t;

    phase_t      r_phase;
    logic        r_phi2Prev;
    logic        r_ioArmed;
    logic [3:0]  r_ioOp;
    logic        r_selected;
    logic        r_chrArm;
    logic [1:0]  r_regPtr;
    logic [3:0]  r_chrPtr;
    logic [3:0]  r_dout;
    logic        r_doe;

    logic [3:0]  r_main   [4][16];
    logic [3:0]  r_status [4][4];

    logic        w_advance;
    phase_t      w_nextPhase;
    logic        w_execX2;
    logic        w_isRead;
    logic        w_wrMain;
    logic        w_wrStatus;
    logic [3:0]  w_rdData;

    // A phase step is a clean PHI2 rising edge; edges that arrive while
    // PHI1 is still high are treated as glitches and ignored.
    assign w_advance = PHI2_i & ~r_phi2Prev & ~PHI1_i;

    // SYNC overrides the sequence; X3 (3'd7) naturally wraps to A1 (3'd0).
    always_comb begin
        w_nextPhase = phase_t'(r_phase + 3'd1);
        if (SYNC_i) begin
            w_nextPhase = PH_A1;
        end
    end

    // An I/O instruction executes on the step into X2, only for the
    // selected chip.
    assign w_execX2 = w_advance && (w_nextPhase == PH_X2) && r_ioArmed && r_selected;

    // Read codes: SBM(8), RDM(9), ADM(B), RD0-RD3(C-F).
    assign w_isRead = (r_ioOp == 4'h8) || (r_ioOp == 4'h9) ||
                      (r_ioOp == 4'hB) || (r_ioOp[3:2] == 2'b11);

    assign w_wrMain   = w_execX2 && (r_ioOp == 4'h0);
    assign w_wrStatus = w_execX2 && (r_ioOp[3:2] == 2'b01);

    assign w_rdData = (r_ioOp[3:2] == 2'b11) ? r_status[r_regPtr][r_ioOp[1:0]]
                                             : r_main[r_regPtr][r_chrPtr];

    // Phase tracking, SRC/I/O decode and the registered bus driver.
    // Every advance drops the bus; only the step into X2 of a read
    // re-enables it, so the drive lasts exactly one phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_phase    <= PH_A1;
            r_phi2Prev <= 1'b0;
            r_ioArmed  <= 1'b0;
            r_ioOp     <= 4'h0;
            r_selected <= 1'b0;
            r_chrArm   <= 1'b0;
            r_regPtr   <= 2'd0;
            r_chrPtr   <= 4'h0;
            r_dout     <= 4'h0;
            r_doe      <= 1'b0;
        end else begin
            r_phi2Prev <= PHI2_i;
            if (w_advance) begin
                r_phase <= w_nextPhase;
                r_doe   <= 1'b0;
                r_dout  <= 4'h0;
                case (w_nextPhase)
                    PH_A1: begin
                        r_ioArmed <= 1'b0;
                        r_chrArm  <= 1'b0;
                    end
                    PH_M2: begin
                        if (CM_i) begin
                            r_ioOp    <= D_i;
                            r_ioArmed <= 1'b1;
                        end
                    end
                    PH_X2: begin
                        if (r_ioArmed) begin
                            if (r_selected && w_isRead) begin
                                r_doe  <= 1'b1;
                                r_dout <= w_rdData;
                            end
                        end else if (CM_i) begin
                            // SRC: the high address nibble picks the chip.
                            r_selected <= (D_i[3:2] == CHIP_ID);
                            r_regPtr   <= D_i[1:0];
                            r_chrArm   <= 1'b1;
                        end
                    end
                    PH_X3: begin
                        if (r_chrArm && r_selected) begin
                            r_chrPtr <= D_i;
                        end
                        r_chrArm <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Memory array: deliberately not reset so contents survive a reset.
    always_ff @(posedge clk_i) begin
        if (w_wrMain) begin
            r_main[r_regPtr][r_chrPtr] <= D_i;
        end
        if (w_wrStatus) begin
            r_status[r_regPtr][r_ioOp[1:0]] <= D_i;
        end
    end

`ifdef I4002_OUTPUT_PORT_EN
    logic [3:0] r_port;

    // WMP (code 1) latches the X2 data onto the output port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_port <= 4'h0;
        end else if (w_execX2 && (r_ioOp == 4'h1)) begin
            r_port <= D_i;
        end
    end

    assign PORT_o = r_port;
`else
    assign PORT_o = 4'h0;
`endif

    assign D_o    = r_dout;
    assign D_oe_o = r_doe;

endmodule

// File: tb/tb_i4002_ram.sv
// ---------------------------------------------------------------------------
// tb_i4002_ram -- directed self-checking bench for i4002_ram.
// Two chips share the bus: dut0 (CHIP_ID 0) and dut1 (CHIP_ID 1). The bench
// plays the CPU role, producing PHI1/PHI2/SYNC/CM and bus data phase by phase.
// ---------------------------------------------------------------------------
module tb_i4002_ram;

    logic       clk;
    logic       rst_n;
    logic       phi1;
    logic       phi2;
    logic       sync;
    logic       cm;
    logic [3:0] dIn;

    logic [3:0] dOut0, dOut1;
    logic       dOe0, dOe1;
    logic [3:0] port0, port1;

    int checks = 0;
    int errors = 0;

    // Per-cycle captures
    logic       oeX1_0, oeX2_0, oeX3_0, oeA1_0, oeAny0, oeAny1;
    logic [3:0] doX2_0, doX2_1, portX2_0, portX3_0;
    logic       oeX2_1;

    logic [3:0] expPortC;

    i4002_ram #(.CHIP_ID(2'd0)) dut0 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .PHI1_i (phi1),
        .PHI2_i (phi2),
        .SYNC_i (sync),
        .CM_i   (cm),
        .D_i    (dIn),
        .D_o    (dOut0),
        .D_oe_o (dOe0),
        .PORT_o (port0)
    );

    i4002_ram #(.CHIP_ID(2'd1)) dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .PHI1_i (phi1),
        .PHI2_i (phi2),
        .SYNC_i (sync),
        .CM_i   (cm),
        .D_i    (dIn),
        .D_o    (dOut1),
        .D_oe_o (dOe1),
        .PORT_o (port1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive the bus for the phase being entered, then give one PHI1 pulse
    // followed by one PHI2 pulse; returns at a negedge inside the new phase.
    task automatic applyStimulus(input logic [3:0] d, input logic cmv, input logic syncv);
        @(negedge clk);
        dIn  = d;
        cm   = cmv;
        sync = syncv;
        phi1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        phi1 = 1'b0;
        @(negedge clk);
        phi2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        phi2 = 1'b0;
        oeAny0 = oeAny0 | dOe0;
        oeAny1 = oeAny1 | dOe1;
    endtask

    // PHI2 pulse while PHI1 is still high: must not count as a phase step.
    task automatic glitchPhi2();
        @(negedge clk);
        phi1 = 1'b1;
        @(negedge clk);
        phi2 = 1'b1;
        @(negedge clk);
        phi2 = 1'b0;
        @(negedge clk);
        phi1 = 1'b0;
    endtask

    // One full instruction cycle starting in A1 and ending back in A1.
    task automatic busCycle(input logic [3:0] opr, input logic cmOp,
                            input logic [3:0] dX2, input logic cmX2,
                            input logic [3:0] dX3, input logic glitch);
        oeAny0 = 1'b0;
        oeAny1 = 1'b0;
        applyStimulus(4'h0, 1'b0, 1'b0);   // A2
        applyStimulus(4'h0, 1'b0, 1'b0);   // A3
        applyStimulus(4'h0, 1'b0, 1'b0);   // M1
        applyStimulus(opr, cmOp, 1'b0);    // M2
        applyStimulus(4'h0, 1'b0, 1'b0);   // X1
        oeX1_0 = dOe0;
        if (glitch) glitchPhi2();
        applyStimulus(dX2, cmX2, 1'b0);    // X2
        oeX2_0   = dOe0;
        doX2_0   = dOut0;
        oeX2_1   = dOe1;
        doX2_1   = dOut1;
        portX2_0 = port0;
        applyStimulus(dX3, 1'b0, 1'b0);    // X3
        oeX3_0   = dOe0;
        portX3_0 = port0;
        applyStimulus(4'h0, 1'b0, 1'b1);   // A1 (SYNC during X3)
        oeA1_0 = dOe0;
    endtask

    task automatic srcCycle(input logic [3:0] regAddr, input logic [3:0] chr);
        busCycle(4'h0, 1'b0, regAddr, 1'b1, chr, 1'b0);
    endtask

    task automatic ioCycle(input logic [3:0] op, input logic [3:0] data);
        busCycle(op, 1'b1, data, 1'b0, 4'h0, 1'b0);
    endtask

    initial begin
`ifdef I4002_OUTPUT_PORT_EN
        expPortC = 4'hC;
`else
        expPortC = 4'h0;
`endif
        rst_n = 1'b0;
        phi1 = 1'b0;
        phi2 = 1'b0;
        sync = 1'b0;
        cm   = 1'b0;
        dIn  = 4'h0;
        repeat (3) @(negedge clk);
        checkOutput("rst_oe0",   {7'd0, dOe0}, 8'h00);
        checkOutput("rst_do0",   {4'd0, dOut0}, 8'h00);
        checkOutput("rst_port0", {4'd0, port0}, 8'h00);
        checkOutput("rst_oe1",   {7'd0, dOe1}, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // SRC reg 2 char 5 on chip 0, WRM A, then RDM
        srcCycle(4'b0010, 4'h5);
        ioCycle(4'h0, 4'hA);
        checkOutput("wrm_oeX2", {7'd0, oeX2_0}, 8'h00);
        ioCycle(4'h9, 4'h0);
        checkOutput("rdm_oeX1",  {7'd0, oeX1_0}, 8'h00);
        checkOutput("rdm_oeX2",  {7'd0, oeX2_0}, 8'h01);
        checkOutput("rdm_doX2",  {4'd0, doX2_0}, 8'h0A);
        checkOutput("rdm_oeX3",  {7'd0, oeX3_0}, 8'h00);
        checkOutput("rdm_oeA1",  {7'd0, oeA1_0}, 8'h00);
        checkOutput("rdm_chip1_quiet", {7'd0, oeAny1}, 8'h00);

        // Status characters of register 2
        ioCycle(4'h6, 4'h7);               // WR2
        ioCycle(4'h5, 4'h3);               // WR1
        ioCycle(4'hE, 4'h0);               // RD2
        checkOutput("rd2", {3'd0, oeX2_0, doX2_0}, 8'h17);
        ioCycle(4'hD, 4'h0);               // RD1
        checkOutput("rd1", {3'd0, oeX2_0, doX2_0}, 8'h13);

        // Output port
        ioCycle(4'h1, 4'hC);               // WMP
        checkOutput("wmp_portX2", {4'd0, portX2_0}, {4'd0, expPortC});
        checkOutput("wmp_portX3", {4'd0, portX3_0}, {4'd0, expPortC});
        checkOutput("wmp_oeAny",  {7'd0, oeAny0}, 8'h00);
        ioCycle(4'h9, 4'h0);
        checkOutput("wmp_port_held", {4'd0, port0}, {4'd0, expPortC});
        checkOutput("wmp_port_chip1", {4'd0, port1}, 8'h00);

        // Address chip 1: chip 0 must deselect and stay off the bus
        srcCycle(4'b0100, 4'h3);
        ioCycle(4'h0, 4'h6);
        ioCycle(4'h9, 4'h0);
        checkOutput("chip1_rdm", {3'd0, oeX2_1, doX2_1}, 8'h16);
        checkOutput("chip0_deselected", {7'd0, oeAny0}, 8'h00);

        // Back to chip 0; other read flavours of the same character
        srcCycle(4'b0010, 4'h5);
        checkOutput("src0_chip1_quiet", {7'd0, oeAny1}, 8'h00);
        ioCycle(4'hB, 4'h0);               // ADM
        checkOutput("adm", {3'd0, oeX2_0, doX2_0}, 8'h1A);
        checkOutput("adm_chip1_quiet", {7'd0, oeAny1}, 8'h00);
        ioCycle(4'h8, 4'h0);               // SBM
        checkOutput("sbm", {3'd0, oeX2_0, doX2_0}, 8'h1A);

        // SYNC at M1 aborts a WRM before it is latched
        oeAny0 = 1'b0;
        applyStimulus(4'h9, 1'b0, 1'b0);   // A2
        applyStimulus(4'h9, 1'b0, 1'b0);   // A3
        applyStimulus(4'h9, 1'b0, 1'b0);   // M1
        applyStimulus(4'h0, 1'b1, 1'b1);   // SYNC -> A1 instead of M2
        busCycle(4'h9, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0);
        checkOutput("abort_rdm", {3'd0, oeX2_0, doX2_0}, 8'h1A);

        // PHI2 glitch under PHI1 must not shift the phase
        busCycle(4'h9, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1);
        checkOutput("glitch_rdm", {3'd0, oeX2_0, doX2_0}, 8'h1A);

        // Unassigned code (2) does nothing: no drive, no write
        ioCycle(4'h2, 4'hF);
        checkOutput("nop_oe", {7'd0, oeAny0}, 8'h00);
        ioCycle(4'h9, 4'h0);
        checkOutput("nop_nowrite", {3'd0, oeX2_0, doX2_0}, 8'h1A);

        // Boundary: last register, last character, last status slot
        srcCycle(4'b0011, 4'hF);
        ioCycle(4'h0, 4'h5);
        ioCycle(4'h7, 4'hE);               // WR3
        ioCycle(4'h9, 4'h0);
        checkOutput("r3c15", {3'd0, oeX2_0, doX2_0}, 8'h15);
        ioCycle(4'hF, 4'h0);               // RD3
        checkOutput("r3_rd3", {3'd0, oeX2_0, doX2_0}, 8'h1E);

        // Register 2 status unaffected by register 3 writes
        srcCycle(4'b0010, 4'h5);
        ioCycle(4'hE, 4'h0);
        checkOutput("rd2_again", {3'd0, oeX2_0, doX2_0}, 8'h17);

        // Reset pulsed during X2 of an RDM
        applyStimulus(4'h0, 1'b0, 1'b0);   // A2
        applyStimulus(4'h0, 1'b0, 1'b0);   // A3
        applyStimulus(4'h0, 1'b0, 1'b0);   // M1
        applyStimulus(4'h9, 1'b1, 1'b0);   // M2
        applyStimulus(4'h0, 1'b0, 1'b0);   // X1
        applyStimulus(4'h0, 1'b0, 1'b0);   // X2
        checkOutput("prereset_oe", {7'd0, dOe0}, 8'h01);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_oe",   {7'd0, dOe0}, 8'h00);
        checkOutput("reset_do",   {4'd0, dOut0}, 8'h00);
        checkOutput("reset_port", {4'd0, port0}, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sync  = 1'b0;
        repeat (2) @(negedge clk);

        // Phase restarts at A1; memory keeps its contents but selection is lost
        ioCycle(4'h9, 4'h0);
        checkOutput("postreset_unselected", {7'd0, oeAny0}, 8'h00);
        srcCycle(4'b0010, 4'h5);
        ioCycle(4'h9, 4'h0);
        checkOutput("postreset_rdm", {3'd0, oeX2_0, doX2_0}, 8'h1A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i4002_ram.md
I4002_RAM -- requirements
Module: i4002_ram

Interface
REQ-001 SHALL have parameter CHIP_ID, default 2'd0, chip number matched against SRC bits D3:D2.
REQ-002 SHALL have port clk_i  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port PHI1_i  input  1  two-phase clock phase 1 from mcs4_clk_gen, sampled on clk_i.
REQ-005 SHALL have port PHI2_i  input  1  two-phase clock phase 2, sampled on clk_i.
REQ-006 SHALL have port SYNC_i  input  1  CPU SYNC; high during X3, marks that the next phase is A1.
REQ-007 SHALL have port CM_i  input  1  CM-RAM line from the CPU.
REQ-008 SHALL have port D_i  input  4  data bus driven by the CPU.
REQ-009 SHALL have port D_o  output  4  data bus value driven by the RAM.
REQ-010 SHALL have port D_oe_o  output  1  RAM bus-drive enable.
REQ-011 SHALL have port PORT_o  output  4  latched output port.

Function
REQ-012 SHALL keep an 8-state phase counter A1,A2,A3,M1,M2,X1,X2,X3 that advances once per detected PHI2_i rising edge (previous sample 0, current sample 1).
REQ-013 SHALL force the next phase to A1 when SYNC_i is high at the advancing edge; without SYNC, X3 wraps to A1.
REQ-014 SHALL contain 4 registers, each with 16 main 4-bit characters and 4 status 4-bit characters (320 bits).
REQ-015 SHALL, at entry to M2 with CM_i=1, latch D_i as io_op and set io_armed; io_armed SHALL clear at entry to A1.
REQ-016 SHALL, at X2 with CM_i=1 and io_armed=0 (SRC), set selected = (D_i[3:2]==CHIP_ID), latch D_i[1:0] as register pointer, and arm character latch.
REQ-017 SHALL, at X3 following an SRC X2 while selected, latch D_i as character pointer.
REQ-018 SHALL, at X2 with io_armed=1 and selected=1, execute io_op: 0 WRM writes D_i to main[reg][char]; 1 WMP writes D_i to PORT_o; 4-7 WR0-WR3 write status[reg][io_op-4]; 8 SBM, 9 RDM, B ADM read main[reg][char]; C-F RD0-RD3 read status[reg][io_op-C]; other codes no action.
REQ-019 SHALL assert D_oe_o with the read data on D_o for the whole X2 phase of a read op and only then; otherwise D_oe_o=0 and D_o=4'h0.
REQ-020 SHALL never drive the bus while not selected; an SRC addressed to another chip SHALL clear selected.
REQ-021 SHALL, for writes, use the D_i value sampled at X2 entry; a write and a same-cycle read of the same location are impossible by construction.
REQ-022 SHALL ignore PHI1_i except as a qualifier: PHI2 edges seen while PHI1_i=1 SHALL NOT advance the phase.

Reset
REQ-023 SHALL, on rst_ni=0, immediately clear phase to A1, io_armed, selected, register/character pointers, PORT_o=4'h0, D_o=4'h0, D_oe_o=0.
REQ-024 SHALL leave the memory array uninitialised by reset; reset mid-cycle SHALL abort any pending op with no write.

Configuration
REQ-025 SHALL support macro I4002_OUTPUT_PORT_EN: defined -> WMP updates PORT_o; undefined -> no port register, PORT_o tied to 4'h0, WMP a no-op.

Verification
REQ-026 SHALL verify: SRC with D=4'b0010 at X2, D=4'h5 at X3, then WRM with D=4'hA -> main[2][5]=4'hA; later RDM -> D_o=4'hA, D_oe_o=1 during X2 only.
REQ-027 SHALL verify: CHIP_ID=1, SRC D=4'b0000 -> selected=0; subsequent RDM -> D_oe_o stays 0 throughout.
REQ-028 SHALL verify: WR2 with D=4'h7 then RD2 -> D_o=4'h7; RD1 on same register returns its own written value, not 4'h7.
REQ-029 SHALL verify: with I4002_OUTPUT_PORT_EN, WMP D=4'hC -> PORT_o=4'hC from X2 onward and held; without macro PORT_o=4'h0.
REQ-030 SHALL verify: SYNC_i asserted mid-cycle (at M1) -> next phase A1, pending io_armed cleared, no write.
REQ-031 SHALL verify: rst_ni pulsed low during X2 of RDM -> D_oe_o=0 and PORT_o=4'h0 in the same cycle, phase=A1 after release.
